// File: rtl/reorder_buffer_pkg.sv
// Shared core types and the reorder buffer's own types.
// common carries machine-wide widths; rob_pkg carries ROB sizing and entry layout.
package common;
  localparam int MACHINE_WIDTH = 2;
  localparam int FU_NUM        = 4;
  localparam int XLEN          = 32;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [5:0]      preg_addr_t;
  typedef logic [4:0]      creg_addr_t;
endpackage

package rob_pkg;
  import common::*;

  localparam int ROB_DEPTH  = 16;
  localparam int ROB_ADDR_W = $clog2(ROB_DEPTH);

  typedef logic [ROB_ADDR_W-1:0] rob_addr_t;
  typedef logic [ROB_ADDR_W:0]   rob_cnt_t;

  typedef struct packed {
    word_t      pc;
    creg_addr_t arch_dst;
    preg_addr_t preg_dst;
    word_t      data;
    logic       exc;
  } rob_entry_t;

  // Slot vectors are packed from bit 0, so a popcount is the number of slots used.
  function automatic rob_cnt_t slot_count(input logic [MACHINE_WIDTH-1:0] slots);
    rob_cnt_t n;
    n = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      n = n + rob_cnt_t'(slots[i]);
    end
    return n;
  endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// Rename/writeback/commit bus of the reorder buffer.
// master is the pipeline side driving requests, slave is the buffer itself.
interface reorder_buffer_if;
  import common::*;
  import rob_pkg::*;

  logic       [MACHINE_WIDTH-1:0] alloc_valid;
  rob_entry_t [MACHINE_WIDTH-1:0] alloc_entry;
  logic                           alloc_ready;
  rob_addr_t  [MACHINE_WIDTH-1:0] rob_addr;

  logic       [FU_NUM-1:0]        wb_valid;
  rob_addr_t  [FU_NUM-1:0]        wb_rob_addr;
  word_t      [FU_NUM-1:0]        wb_data;
  logic       [FU_NUM-1:0]        wb_exc;

  logic       [MACHINE_WIDTH-1:0] commit_valid;
  rob_entry_t [MACHINE_WIDTH-1:0] commit_entry;
  logic                           flush;
  logic                           empty;

  modport master (
    output alloc_valid, alloc_entry, wb_valid, wb_rob_addr, wb_data, wb_exc,
    input  alloc_ready, rob_addr, commit_valid, commit_entry, flush, empty
  );

  modport slave (
    input  alloc_valid, alloc_entry, wb_valid, wb_rob_addr, wb_data, wb_exc,
    output alloc_ready, rob_addr, commit_valid, commit_entry, flush, empty
  );
endinterface

// File: rtl/reorder_buffer_entry_array.sv
// Entry storage for the reorder buffer: allocation and writeback write ports,
// head read ports, and retire ports that clear the valid bit of committed entries.
module rob_entry_array
  import common::*;
  import rob_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic       [MACHINE_WIDTH-1:0] alloc_we,
  input  rob_addr_t  [MACHINE_WIDTH-1:0] alloc_addr,
  input  rob_entry_t [MACHINE_WIDTH-1:0] alloc_entry,
  input  logic       [FU_NUM-1:0]        wb_we,
  input  rob_addr_t  [FU_NUM-1:0]        wb_addr,
  input  word_t      [FU_NUM-1:0]        wb_data,
  input  logic       [FU_NUM-1:0]        wb_exc,
  input  logic       [MACHINE_WIDTH-1:0] retire_we,
  input  rob_addr_t  [MACHINE_WIDTH-1:0] rd_addr,
  output rob_entry_t [MACHINE_WIDTH-1:0] rd_entry,
  output logic       [MACHINE_WIDTH-1:0] rd_valid,
  output logic       [MACHINE_WIDTH-1:0] rd_complete
);

  logic       [ROB_DEPTH-1:0] valid_q;
  logic       [ROB_DEPTH-1:0] complete_q;
  rob_entry_t                 entry_q [ROB_DEPTH];

  // Flush drops every entry and discards same-cycle allocation and writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= '0;
      complete_q <= '0;
      for (int e = 0; e < ROB_DEPTH; e++) begin
        entry_q[e] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
        if (alloc_we[i]) begin
          valid_q[alloc_addr[i]]       <= 1'b1;
          complete_q[alloc_addr[i]]    <= 1'b0;
          entry_q[alloc_addr[i]]       <= alloc_entry[i];
          entry_q[alloc_addr[i]].data  <= '0;
          entry_q[alloc_addr[i]].exc   <= 1'b0;
        end
      end
      for (int k = 0; k < FU_NUM; k++) begin
        if (wb_we[k] && valid_q[wb_addr[k]]) begin
          complete_q[wb_addr[k]]   <= 1'b1;
          entry_q[wb_addr[k]].data <= wb_data[k];
          entry_q[wb_addr[k]].exc  <= wb_exc[k];
        end
      end
      for (int i = 0; i < MACHINE_WIDTH; i++) begin
        if (retire_we[i]) begin
          valid_q[rd_addr[i]] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_entry    = '0;
    rd_valid    = '0;
    rd_complete = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      rd_entry[i]    = entry_q[rd_addr[i]];
      rd_valid[i]    = valid_q[rd_addr[i]];
      rd_complete[i] = complete_q[rd_addr[i]];
    end
  end

  // Writebacks must target live entries, and no two ports may hit the same one.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      for (int k = 0; k < FU_NUM; k++) begin
        if (wb_we[k]) begin
          assert (valid_q[wb_addr[k]]);
        end
        for (int j = k + 1; j < FU_NUM; j++) begin
          if (wb_we[k] && wb_we[j]) begin
            assert (wb_addr[k] != wb_addr[j]);
          end
        end
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer between rename and commit.
// Owns head/tail/count, in-order commit selection and exception flush.
module reorder_buffer
  import common::*;
  import rob_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  reorder_buffer_if.slave bus
);

  rob_addr_t                      head;
  rob_addr_t                      tail;
  rob_cnt_t                       count;

  rob_addr_t  [MACHINE_WIDTH-1:0] tail_addr;
  rob_addr_t  [MACHINE_WIDTH-1:0] head_addr;
  rob_entry_t [MACHINE_WIDTH-1:0] head_entry;
  logic       [MACHINE_WIDTH-1:0] head_valid;
  logic       [MACHINE_WIDTH-1:0] head_complete;
  logic       [MACHINE_WIDTH-1:0] alloc_we;
  logic       [MACHINE_WIDTH-1:0] commit;
  logic                           alloc_ready;
  logic                           flush;
  rob_cnt_t                       n_alloc;
  rob_cnt_t                       n_commit;

  always_comb begin
    tail_addr = '0;
    head_addr = '0;
    for (int i = 0; i < MACHINE_WIDTH; i++) begin
      tail_addr[i] = tail + rob_addr_t'(i);
      head_addr[i] = head + rob_addr_t'(i);
    end
  end

  // Readiness is judged on the count before this cycle's commits, which is conservative.
  assign alloc_ready = (count <= rob_cnt_t'(ROB_DEPTH - MACHINE_WIDTH));
  assign alloc_we    = bus.alloc_valid & {MACHINE_WIDTH{alloc_ready}};

  // An excepting entry may only retire from slot 0, and stops every younger slot.
  always_comb begin
    commit    = '0;
    commit[0] = head_valid[0] & head_complete[0];
    for (int i = 1; i < MACHINE_WIDTH; i++) begin
      commit[i] = commit[i-1] & head_valid[i] & head_complete[i]
                & ~head_entry[i].exc & ~head_entry[i-1].exc;
    end
  end

  assign flush    = commit[0] & head_entry[0].exc;
  assign n_alloc  = slot_count(alloc_we);
  assign n_commit = slot_count(commit);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + rob_addr_t'(n_commit);
      tail  <= tail + rob_addr_t'(n_alloc);
      count <= count + n_alloc - n_commit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(|bus.alloc_valid) || alloc_ready);
    end
  end

  rob_entry_array u_entries (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .alloc_we    (alloc_we),
    .alloc_addr  (tail_addr),
    .alloc_entry (bus.alloc_entry),
    .wb_we       (bus.wb_valid),
    .wb_addr     (bus.wb_rob_addr),
    .wb_data     (bus.wb_data),
    .wb_exc      (bus.wb_exc),
    .retire_we   (commit),
    .rd_addr     (head_addr),
    .rd_entry    (head_entry),
    .rd_valid    (head_valid),
    .rd_complete (head_complete)
  );

  assign bus.alloc_ready  = alloc_ready;
  assign bus.rob_addr     = tail_addr;
  assign bus.commit_valid = commit;
  assign bus.commit_entry = head_entry;
  assign bus.flush        = flush;
  assign bus.empty        = (count == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, out-of-order writeback,
// full/wrap behaviour, exception flush, steady-state throughput and mid-stream reset.
module tb_reorder_buffer;
  import common::*;
  import rob_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_valid = '0;
    bus.alloc_entry = '0;
    bus.wb_valid    = '0;
    bus.wb_rob_addr = '0;
    bus.wb_data     = '0;
    bus.wb_exc      = '0;
  endtask

  task automatic drive_alloc(input logic [MACHINE_WIDTH-1:0] slots, input word_t pc0, input word_t pc1);
    bus.alloc_valid    = slots;
    bus.alloc_entry[0] = '{pc: pc0, arch_dst: 5'd3, preg_dst: 6'd33, data: '0, exc: 1'b0};
    bus.alloc_entry[1] = '{pc: pc1, arch_dst: 5'd4, preg_dst: 6'd34, data: '0, exc: 1'b0};
  endtask

  task automatic drive_wb(input int port, input rob_addr_t addr, input word_t data, input logic exc);
    bus.wb_valid[port]    = 1'b1;
    bus.wb_rob_addr[port] = addr;
    bus.wb_data[port]     = data;
    bus.wb_exc[port]      = exc;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    settle();

    // Reset state
    check_output("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    check_output("rst_empty", 64'(bus.empty), 64'd1);
    check_output("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
    check_output("rst_flush", 64'(bus.flush), 64'd0);
    check_output("rst_rob_addr0", 64'(bus.rob_addr[0]), 64'd0);
    check_output("rst_rob_addr1", 64'(bus.rob_addr[1]), 64'd1);

    // First allocation of two entries
    drive_alloc(2'b11, 32'h100, 32'h104);
    settle();
    check_output("alloc_addr0", 64'(bus.rob_addr[0]), 64'd0);
    check_output("alloc_addr1", 64'(bus.rob_addr[1]), 64'd1);
    check_output("alloc_same_cycle_commit", 64'(bus.commit_valid), 64'd0);
    tick();
    idle_inputs();
    settle();
    check_output("alloc_count", 64'(dut.count), 64'd2);
    check_output("alloc_empty", 64'(bus.empty), 64'd0);
    check_output("alloc_tail", 64'(bus.rob_addr[0]), 64'd2);

    // Out-of-order writeback: entry 1 first, then entry 0
    drive_wb(0, 4'd1, 32'hA1, 1'b0);
    tick();
    idle_inputs();
    settle();
    check_output("ooo_no_commit", 64'(bus.commit_valid), 64'd0);
    drive_wb(1, 4'd0, 32'hA0, 1'b0);
    tick();
    idle_inputs();
    settle();
    check_output("ooo_commit_valid", 64'(bus.commit_valid), 64'd3);
    check_output("ooo_pc0", 64'(bus.commit_entry[0].pc), 64'h100);
    check_output("ooo_data0", 64'(bus.commit_entry[0].data), 64'hA0);
    check_output("ooo_pc1", 64'(bus.commit_entry[1].pc), 64'h104);
    check_output("ooo_data1", 64'(bus.commit_entry[1].data), 64'hA1);
    check_output("ooo_flush", 64'(bus.flush), 64'd0);
    tick();
    check_output("ooo_empty_after", 64'(bus.empty), 64'd1);
    check_output("ooo_head_after", 64'(dut.head), 64'd2);

    // Fill from head=tail=2: seven pairs bring count to 14 with the tail wrapped to 0
    for (int k = 0; k < 7; k++) begin
      drive_alloc(2'b11, 32'h200 + 32'(8 * k + 8), 32'h200 + 32'(8 * k + 12));
      settle();
      check_output("fill_addr0", 64'(bus.rob_addr[0]), 64'(2 + 2 * k));
      check_output("fill_ready", 64'(bus.alloc_ready), 64'd1);
      tick();
      idle_inputs();
    end
    settle();
    check_output("fill_count14", 64'(dut.count), 64'd14);
    check_output("fill_ready14", 64'(bus.alloc_ready), 64'd1);
    drive_alloc(2'b01, 32'h200, 32'h0);
    settle();
    check_output("wrap_addr0", 64'(bus.rob_addr[0]), 64'd0);
    tick();
    idle_inputs();
    settle();
    check_output("fill_count15", 64'(dut.count), 64'd15);
    check_output("fill_ready15", 64'(bus.alloc_ready), 64'd0);
    check_output("wrap_tail", 64'(bus.rob_addr[0]), 64'd1);

    // Free two entries at a full buffer
    drive_wb(0, 4'd2, 32'hB2, 1'b0);
    drive_wb(1, 4'd3, 32'hB3, 1'b0);
    tick();
    idle_inputs();
    settle();
    check_output("full_commit_valid", 64'(bus.commit_valid), 64'd3);
    check_output("full_commit_pc0", 64'(bus.commit_entry[0].pc), 64'h208);
    check_output("full_ready_during_commit", 64'(bus.alloc_ready), 64'd0);
    tick();
    check_output("full_count13", 64'(dut.count), 64'd13);
    check_output("full_ready13", 64'(bus.alloc_ready), 64'd1);
    check_output("full_head", 64'(dut.head), 64'd4);
    check_output("full_addr1", 64'(bus.rob_addr[1]), 64'd2);

    // Exception flush: entry 3 excepts while 4 and 5 are complete
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_alloc(2'b11, 32'h300 + 32'(8 * k), 32'h304 + 32'(8 * k));
      tick();
      idle_inputs();
    end
    drive_wb(0, 4'd0, 32'hC0, 1'b0);
    drive_wb(1, 4'd1, 32'hC1, 1'b0);
    drive_wb(2, 4'd2, 32'hC2, 1'b0);
    drive_wb(3, 4'd4, 32'hC4, 1'b0);
    tick();
    idle_inputs();
    settle();
    check_output("exc_pre_commit01", 64'(bus.commit_valid), 64'd3);
    drive_wb(0, 4'd5, 32'hC5, 1'b0);
    tick();
    idle_inputs();
    settle();
    check_output("exc_head2", 64'(dut.head), 64'd2);
    check_output("exc_commit2_only", 64'(bus.commit_valid), 64'd1);
    check_output("exc_no_flush_yet", 64'(bus.flush), 64'd0);
    drive_wb(0, 4'd3, 32'hDEAD, 1'b1);
    tick();
    idle_inputs();
    drive_alloc(2'b11, 32'h400, 32'h404);
    settle();
    check_output("exc_commit_valid", 64'(bus.commit_valid), 64'd1);
    check_output("exc_flush", 64'(bus.flush), 64'd1);
    check_output("exc_pc", 64'(bus.commit_entry[0].pc), 64'h30C);
    check_output("exc_bit", 64'(bus.commit_entry[0].exc), 64'd1);
    check_output("exc_data", 64'(bus.commit_entry[0].data), 64'hDEAD);
    tick();
    idle_inputs();
    settle();
    check_output("flush_count", 64'(dut.count), 64'd0);
    check_output("flush_head", 64'(dut.head), 64'd0);
    check_output("flush_tail", 64'(bus.rob_addr[0]), 64'd0);
    check_output("flush_empty", 64'(bus.empty), 64'd1);
    check_output("flush_commit_valid", 64'(bus.commit_valid), 64'd0);
    tick();
    check_output("flush_no_late_commit", 64'(bus.commit_valid), 64'd0);
    check_output("flush_still_empty", 64'(bus.empty), 64'd1);

    // Steady state: allocate and commit two each in the same cycle at count=8
    for (int k = 0; k < 4; k++) begin
      drive_alloc(2'b11, 32'h500 + 32'(8 * k), 32'h504 + 32'(8 * k));
      tick();
      idle_inputs();
    end
    drive_wb(0, 4'd0, 32'hE0, 1'b0);
    drive_wb(1, 4'd1, 32'hE1, 1'b0);
    tick();
    idle_inputs();
    drive_alloc(2'b11, 32'h520, 32'h524);
    settle();
    check_output("steady_count_before", 64'(dut.count), 64'd8);
    check_output("steady_commit_valid", 64'(bus.commit_valid), 64'd3);
    check_output("steady_alloc_addr0", 64'(bus.rob_addr[0]), 64'd8);
    tick();
    idle_inputs();
    settle();
    check_output("steady_count_after", 64'(dut.count), 64'd8);
    check_output("steady_head", 64'(dut.head), 64'd2);
    check_output("steady_tail", 64'(bus.rob_addr[0]), 64'd10);

    // Mid-stream reset with ten live entries
    drive_alloc(2'b11, 32'h528, 32'h52C);
    tick();
    idle_inputs();
    settle();
    check_output("midrst_count_before", 64'(dut.count), 64'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check_output("midrst_empty", 64'(bus.empty), 64'd1);
    check_output("midrst_ready", 64'(bus.alloc_ready), 64'd1);
    check_output("midrst_commit_valid", 64'(bus.commit_valid), 64'd0);
    check_output("midrst_tail", 64'(bus.rob_addr[0]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular in-order reorder buffer for the out-of-order core. It sits between renaming (allocation) and commit (retirement).
- Renaming allocates up to MACHINE_WIDTH entries per cycle, and the buffer returns the ROB addresses used to tag those instructions.
- The execute units write results back by ROB address.
- The buffer retires completed entries from the head, in program order, to the commit stage, and raises a flush when an excepting instruction reaches the head.

## Interface
Parameters:
- ROB_DEPTH, 16: entry count; power of two, ≥ 4.
- MACHINE_WIDTH, 2: allocate/commit slots per cycle.
- FU_NUM, 4: writeback ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- alloc_valid  in  MACHINE_WIDTH  per-slot allocate request; packed (slot i valid implies slot i-1 valid).
- alloc_entry  in  MACHINE_WIDTH × rob_entry_t  fields written at allocation: pc, arch dst, preg dst.
- alloc_ready  out  1  free entries ≥ MACHINE_WIDTH.
- rob_addr  out  MACHINE_WIDTH × rob_addr_t  combinational; tail+i for slot i.
- wb_valid  in  FU_NUM  writeback strobe.
- wb_rob_addr  in  FU_NUM × rob_addr_t  target entry.
- wb_data  in  FU_NUM × word_t  result.
- wb_exc  in  FU_NUM  the instruction raised an exception.
- commit_valid  out  MACHINE_WIDTH  slot retires this cycle.
- commit_entry  out  MACHINE_WIDTH × rob_entry_t  head+i contents, including data and exc.
- flush  out  1  head exception retiring this cycle.
- empty  out  1  count == 0.

## Operation
State:
- head and tail pointers, log2(ROB_DEPTH) bits, natural wrap.
- count, log2(ROB_DEPTH)+1 bits.
- per-entry valid, complete, exc, data, plus the allocation fields.

Allocation:
- Only when alloc_ready is high. Requests while alloc_ready is low are illegal (assertion).
- Slot i writes entry tail+i with valid=1, complete=0, exc=0.
- tail advances by popcount(alloc_valid).

Writeback:
- Each wb_valid[k] sets complete=1 and writes data and exc at wb_rob_addr[k].
- Writeback to an invalid entry is ignored and flagged by assertion.
- Two ports targeting the same address in the same cycle is illegal.

Commit (combinational from registered state):
- Slot 0 commits when entry head is valid and complete.
- Slot i>0 commits when slot i-1 commits, entry head+i is valid, complete and exc=0, and entry head+i-1 has exc=0.
- An excepting entry therefore retires only in slot 0. In that case flush=1 and commit_valid[i>0]=0.
- Committed entries have valid cleared. head advances by popcount(commit_valid).

Count update:
- count_next = count + allocations − commits.
- alloc_ready uses the current count, before this cycle's commits (conservative).

Flush:
- At the edge where flush=1: head=tail=count=0 and all valid=0.
- Flush has priority over same-cycle allocation and writeback, which are discarded.
- The upstream stages are required to squash the allocation themselves.

Reset:
- head=tail=count=0, all valid/complete/exc=0.
- Outputs after reset: alloc_ready=1, empty=1, commit_valid=0, flush=0, rob_addr={1,0}.

## Timing
- Allocation at edge t makes the entry visible at t+1. rob_addr is valid in the same cycle as alloc_valid.
- Writeback accepted at edge t makes the entry commit-eligible in cycle t+1. There is no same-cycle writeback-to-commit bypass.
- Minimum latency from allocation to commit is 2 cycles.
- Wrap-around: head+i and tail+i are computed modulo ROB_DEPTH.
- Full: count == ROB_DEPTH. alloc_ready drops at count > ROB_DEPTH − MACHINE_WIDTH.
- Empty and simultaneous allocation: commit_valid=0 that cycle, since the entry is not yet complete.
- reset asserted mid-operation behaves identically to flush and additionally clears complete/exc.

## Structure
- rob_pkg holds ROB_DEPTH, rob_addr_t, and rob_entry_t (pc word_t, arch dst creg_addr_t, preg dst preg_addr_t, data word_t, exc).
- common supplies MACHINE_WIDTH, FU_NUM, word_t and preg_addr_t.
- One sub-module, rob_entry_array, holds the entries. It has MACHINE_WIDTH allocation write ports, FU_NUM writeback write ports and MACHINE_WIDTH head read ports.
- reorder_buffer keeps the pointers, count, commit selection and flush.

## Test plan
- Reset, then allocate 2 entries (pc 0x100/0x104) -> rob_addr={1,0}. The next cycle count=2 and empty=0.
- Writeback entry 1 then entry 0 (out of order) -> nothing commits until entry 0 completes. Both then commit in the same cycle, in order 0,1.
- Fill 16 entries -> alloc_ready=0 at count=15. Then commit 2 -> alloc_ready=1 the next cycle. Continue until tail wraps 15→0 and check the addresses.
- Entry 3 writes back with exc=1 while 4 and 5 are complete -> entry 3 retires alone in slot 0 with flush=1. The next cycle count=0, head=tail=0, and entries 4/5 never commit.
- Allocate 2 and commit 2 in the same cycle at count=8 -> count stays 8, head and tail each advance by 2.
- Assert reset for 1 cycle mid-stream with 10 entries live -> the next cycle empty=1, alloc_ready=1, commit_valid=0.
